cache_flush_walker: RTL and testbench
=====================================

CACHE_FLUSH_WALKER -- requirements
Module: cache_flush_walker

Interface
REQ-001 Parameter s_index, default 3, sets the index width; num_sets = 2**s_index.
REQ-002 Parameter s_tag, default 24, sets the tag width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1) is the clock and rst (input, 1) is the asynchronous active-low reset.
REQ-004 flush_start  input  1  requests a full-cache flush walk.
REQ-005 flush_busy  output  1  walk in progress.
REQ-006 flush_done  output  1  single-cycle pulse when the walk completes.
REQ-007 dirty_rindex  output  s_index  read index to the dirty-bit array.
REQ-008 dirty_in  input  1  combinational dirty bit for dirty_rindex.
REQ-009 tag_in  input  s_tag  combinational tag for dirty_rindex, from the tag array.
REQ-010 dirty_load, dirty_windex, dirty_datain  output  1/s_index/1  write port to the dirty array; dirty_datain is constant 0.
REQ-011 wb_req  output  1  writeback request to the memory side.
REQ-012 wb_index, wb_tag  output  s_index/s_tag  set and tag of the line to write back.
REQ-013 wb_ack  input  1  memory side has accepted the writeback.

Function
REQ-014 The FSM SHALL have the states IDLE, SCAN, WB, CLEAR and DONE, plus an s_index-bit counter idx and an s_tag-bit register tag_q.
REQ-015 IDLE: busy=0; flush_start=1 -> SCAN next cycle with idx<=0; otherwise stay in IDLE.
REQ-016 SCAN: dirty_rindex=idx.
  - dirty_in=1 -> tag_q<=tag_in and go to WB.
  - dirty_in=0 and idx==num_sets-1 -> DONE.
  - dirty_in=0 otherwise -> idx<=idx+1 and stay in SCAN.
REQ-017 WB: wb_req=1, wb_index=idx, wb_tag=tag_q, all held stable until wb_ack.
  - wb_ack=1 -> CLEAR.
  - The request is never withdrawn.
REQ-018 CLEAR: dirty_load=1, dirty_windex=idx, for exactly one cycle.
  - idx==num_sets-1 -> DONE.
  - Otherwise idx<=idx+1 and go to SCAN.
REQ-019 DONE: flush_done=1 for exactly one cycle, then IDLE.
REQ-020 flush_busy=1 in SCAN, WB, CLEAR and DONE.
REQ-021 flush_start SHALL be ignored whenever the FSM is not in IDLE; flush_start held high re-triggers a walk on the cycle after DONE.
REQ-022 wb_ack SHALL be ignored outside WB; wb_ack arriving in the same cycle wb_req first rises is accepted.
REQ-023 Outside their active states, wb_req=0, dirty_load=0 and flush_done=0; dirty_rindex=idx; wb_index and dirty_windex=idx; wb_tag=tag_q.
REQ-024 idx SHALL never wrap during a walk; termination is decided by the idx==num_sets-1 comparison.
REQ-025 Latency: a clean set costs 1 SCAN cycle; a dirty set costs SCAN + WB (≥1 cycle) + CLEAR.
REQ-026 All outputs SHALL be registered-state decodes, with no combinational path from wb_ack to wb_req.

Reset
REQ-027 Asserting rst low at any time SHALL asynchronously force IDLE, idx=0 and tag_q=0.
REQ-028 During reset, busy, done, wb_req and dirty_load SHALL be 0.
REQ-029 Reset during WB SHALL drop wb_req immediately; no CLEAR occurs, and the dirty bit keeps its value.

Structure
REQ-030 A shared package cache_types SHALL hold the flush_state_t enum (IDLE, SCAN, WB, CLEAR, DONE).
REQ-031 The package SHALL hold the default s_index and s_tag constants.
REQ-032 There SHALL be no sub-module; the dirty and tag arrays are instantiated by the parent, and this block drives their ports.

Verification
REQ-033 All-clean: start pulse at cycle 0, all 8 dirty=0 -> SCAN cycles 1-8, flush_done at cycle 9, wb_req never asserted.
REQ-034 Single dirty: set 5 dirty with tag 0x00ABCD, wb_ack 3 cycles after wb_req -> wb_req held 3 cycles with wb_index=5 and wb_tag=0x00ABCD, then dirty_load=1 with windex=5, walk continues to set 7.
REQ-035 Last set dirty: only set 7 dirty, same-cycle ack -> CLEAR at index 7, then DONE, with no idx wrap to 0.
REQ-036 All dirty with immediate ack -> 8 writebacks at indices 0-7 in order, 8 clears, flush_done exactly once.
REQ-037 flush_start held high throughout and spurious wb_ack pulses in SCAN -> no extra walk mid-flight, spurious acks ignored, new walk starts right after DONE.
REQ-038 rst low while in WB at set 2 -> wb_req=0 immediately, idle after release, set-2 dirty bit still 1.

Source files
------------

// File: rtl/cache_flush_walker_pkg.sv
// ============================================================================
//  Module      : cache_types (package)
//  Description : Shared state encoding and default geometry for the flush walker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_types;

    localparam int S_INDEX_DEF = 3;
    localparam int S_TAG_DEF   = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        WB    = 3'd2,
        CLEAR = 3'd3,
        DONE  = 3'd4
    } flush_state_t;

endpackage : cache_types

`default_nettype wire

// File: rtl/cache_flush_walker_if.sv
// ============================================================================
//  Module      : cache_flush_walker_if
//  Description : Control, dirty/tag array and writeback signals of the walker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_flush_walker_if
    import cache_types::*;
#(
    parameter int s_index = S_INDEX_DEF,
    parameter int s_tag   = S_TAG_DEF
) ();

    logic               flush_start;
    logic               flush_busy;
    logic               flush_done;
    logic [s_index-1:0] dirty_rindex;
    logic               dirty_in;
    logic [s_tag-1:0]   tag_in;
    logic               dirty_load;
    logic [s_index-1:0] dirty_windex;
    logic               dirty_datain;
    logic               wb_req;
    logic [s_index-1:0] wb_index;
    logic [s_tag-1:0]   wb_tag;
    logic               wb_ack;

    // Walker side
    modport master (
        input  flush_start, dirty_in, tag_in, wb_ack,
        output flush_busy, flush_done, dirty_rindex, dirty_load,
               dirty_windex, dirty_datain, wb_req, wb_index, wb_tag
    );

    // Parent side: arrays and memory port
    modport slave (
        output flush_start, dirty_in, tag_in, wb_ack,
        input  flush_busy, flush_done, dirty_rindex, dirty_load,
               dirty_windex, dirty_datain, wb_req, wb_index, wb_tag
    );

endinterface : cache_flush_walker_if

`default_nettype wire

// File: rtl/cache_flush_walker.sv
// ============================================================================
//  Module      : cache_flush_walker
//  Description : Walks every set, writes back dirty lines and clears their bits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_flush_walker
    import cache_types::*;
#(
    parameter int s_index = S_INDEX_DEF,
    parameter int s_tag   = S_TAG_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cache_flush_walker_if.master bus
);

    localparam logic [s_index-1:0] LAST_IDX = '1;

    flush_state_t       state_q, state_d;
    logic [s_index-1:0] idx_q,   idx_d;
    logic [s_tag-1:0]   tag_q,   tag_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
        end
    end

    // Termination uses the LAST_IDX compare so idx never wraps mid-walk.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        case (state_q)
            IDLE: begin
                if (bus.flush_start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (bus.dirty_in) begin
                    tag_d   = bus.tag_in;
                    state_d = WB;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            WB: begin
                if (bus.wb_ack) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = SCAN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; wb_ack never reaches wb_req.
    assign bus.flush_busy   = (state_q != IDLE);
    assign bus.flush_done   = (state_q == DONE);
    assign bus.wb_req       = (state_q == WB);
    assign bus.dirty_load   = (state_q == CLEAR);
    assign bus.dirty_rindex = idx_q;
    assign bus.dirty_windex = idx_q;
    assign bus.dirty_datain = 1'b0;
    assign bus.wb_index     = idx_q;
    assign bus.wb_tag       = tag_q;

endmodule : cache_flush_walker

`default_nettype wire

// File: tb/tb_cache_flush_walker.sv
// ============================================================================
//  Module      : tb_cache_flush_walker
//  Description : Directed self-checking bench with behavioural dirty/tag arrays.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_flush_walker;

    logic        clk;
    logic        rst;
    logic        start;
    logic        man_ack;
    logic        auto_ack;
    logic        dirty_mem [0:7];
    logic [23:0] tag_mem   [0:7];
    int          checks;
    int          errors;

    cache_flush_walker_if #(.s_index(3), .s_tag(24)) bus ();

    cache_flush_walker #(.s_index(3), .s_tag(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.flush_start = start;
    assign bus.dirty_in    = dirty_mem[bus.dirty_rindex];
    assign bus.tag_in      = tag_mem[bus.dirty_rindex];
    assign bus.wb_ack      = auto_ack ? bus.wb_req : man_ack;

    always @(posedge clk) begin
        if (bus.dirty_load) dirty_mem[bus.dirty_windex] <= bus.dirty_datain;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic init_mem(input logic [7:0] dmask);
        for (int i = 0; i < 8; i++) begin
            dirty_mem[i] = dmask[i];
            tag_mem[i]   = 24'h100000 + 24'(i * 24'h111);
        end
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (bus.flush_busy !== 1'b0 || bus.flush_done !== 1'b0 ||
            bus.wb_req !== 1'b0 || bus.dirty_load !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b req=%b load=%b required all 0",
                     bus.flush_busy, bus.flush_done, bus.wb_req, bus.dirty_load);
        end
        checks++;
        if (bus.dirty_rindex !== 3'd0 || bus.wb_tag !== 24'd0) begin
            errors++;
            $display("FAIL reset_regs rindex=%0d tag=%h required 0/0", bus.dirty_rindex, bus.wb_tag);
        end
    endtask

    task automatic test_all_clean;
        init_mem(8'h00);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.dirty_rindex !== 3'(i) || bus.flush_busy !== 1'b1 ||
                bus.wb_req !== 1'b0 || bus.flush_done !== 1'b0) begin
                errors++;
                $display("FAIL clean_scan i=%0d rindex=%0d busy=%b req=%b done=%b",
                         i, bus.dirty_rindex, bus.flush_busy, bus.wb_req, bus.flush_done);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.flush_done !== 1'b1) begin
            errors++;
            $display("FAIL clean_done got %b required 1", bus.flush_done);
        end
        @(negedge clk);
        checks++;
        if (bus.flush_done !== 1'b0 || bus.flush_busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_idle done=%b busy=%b required 0/0", bus.flush_done, bus.flush_busy);
        end
    endtask

    task automatic test_single_dirty;
        init_mem(8'h20);
        tag_mem[5] = 24'h00ABCD;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.dirty_rindex !== 3'(i) || bus.wb_req !== 1'b0) begin
                errors++;
                $display("FAIL single_scan i=%0d rindex=%0d req=%b", i, bus.dirty_rindex, bus.wb_req);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.wb_req !== 1'b1 || bus.wb_index !== 3'd5 || bus.wb_tag !== 24'h00ABCD) begin
                errors++;
                $display("FAIL single_wb k=%0d req=%b index=%0d tag=%h required 1/5/00abcd",
                         k, bus.wb_req, bus.wb_index, bus.wb_tag);
            end
            if (k == 2) man_ack = 1'b1;
            @(negedge clk);
        end
        man_ack = 1'b0;
        checks++;
        if (bus.dirty_load !== 1'b1 || bus.dirty_windex !== 3'd5 ||
            bus.dirty_datain !== 1'b0 || bus.wb_req !== 1'b0) begin
            errors++;
            $display("FAIL single_clear load=%b windex=%0d data=%b req=%b required 1/5/0/0",
                     bus.dirty_load, bus.dirty_windex, bus.dirty_datain, bus.wb_req);
        end
        @(negedge clk);
        checks++;
        if (dirty_mem[5] !== 1'b0 || bus.dirty_rindex !== 3'd6 || bus.dirty_load !== 1'b0) begin
            errors++;
            $display("FAIL single_after bit5=%b rindex=%0d load=%b required 0/6/0",
                     dirty_mem[5], bus.dirty_rindex, bus.dirty_load);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.flush_done !== 1'b1) begin
            errors++;
            $display("FAIL single_done got %b required 1", bus.flush_done);
        end
        @(negedge clk);
    endtask

    task automatic test_last_dirty;
        init_mem(8'h80);
        auto_ack = 1'b1;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.dirty_rindex !== 3'(i) || bus.wb_req !== 1'b0) begin
                errors++;
                $display("FAIL last_scan i=%0d rindex=%0d req=%b", i, bus.dirty_rindex, bus.wb_req);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.wb_req !== 1'b1 || bus.wb_index !== 3'd7 || bus.wb_tag !== tag_mem[7]) begin
            errors++;
            $display("FAIL last_wb req=%b index=%0d tag=%h", bus.wb_req, bus.wb_index, bus.wb_tag);
        end
        @(negedge clk);
        checks++;
        if (bus.dirty_load !== 1'b1 || bus.dirty_windex !== 3'd7) begin
            errors++;
            $display("FAIL last_clear load=%b windex=%0d required 1/7", bus.dirty_load, bus.dirty_windex);
        end
        @(negedge clk);
        checks++;
        if (bus.flush_done !== 1'b1 || bus.dirty_rindex !== 3'd7) begin
            errors++;
            $display("FAIL last_done done=%b rindex=%0d required 1/7", bus.flush_done, bus.dirty_rindex);
        end
        @(negedge clk);
        checks++;
        if (bus.flush_busy !== 1'b0 || bus.dirty_rindex !== 3'd7 || dirty_mem[7] !== 1'b0) begin
            errors++;
            $display("FAIL last_idle busy=%b rindex=%0d bit7=%b required 0/7/0",
                     bus.flush_busy, bus.dirty_rindex, dirty_mem[7]);
        end
        auto_ack = 1'b0;
    endtask

    task automatic test_all_dirty;
        int clears;
        clears = 0;
        init_mem(8'hFF);
        auto_ack = 1'b1;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.dirty_rindex !== 3'(i) || bus.wb_req !== 1'b0) begin
                errors++;
                $display("FAIL all_scan i=%0d rindex=%0d req=%b", i, bus.dirty_rindex, bus.wb_req);
            end
            @(negedge clk);
            checks++;
            if (bus.wb_req !== 1'b1 || bus.wb_index !== 3'(i) || bus.wb_tag !== tag_mem[i]) begin
                errors++;
                $display("FAIL all_wb i=%0d req=%b index=%0d tag=%h", i, bus.wb_req, bus.wb_index, bus.wb_tag);
            end
            @(negedge clk);
            if (bus.dirty_load === 1'b1 && bus.dirty_windex === 3'(i)) clears++;
            @(negedge clk);
        end
        checks++;
        if (clears !== 8 || bus.flush_done !== 1'b1) begin
            errors++;
            $display("FAIL all_clears clears=%0d done=%b required 8/1", clears, bus.flush_done);
        end
        @(negedge clk);
        checks++;
        if (bus.flush_done !== 1'b0 || bus.flush_busy !== 1'b0 || dirty_mem[3] !== 1'b0) begin
            errors++;
            $display("FAIL all_end done=%b busy=%b bit3=%b required 0/0/0",
                     bus.flush_done, bus.flush_busy, dirty_mem[3]);
        end
        auto_ack = 1'b0;
    endtask

    task automatic test_start_held;
        bit seen;
        init_mem(8'h00);
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            man_ack = 1'b1;
            checks++;
            if (bus.dirty_rindex !== 3'(i) || bus.wb_req !== 1'b0 || bus.flush_busy !== 1'b1) begin
                errors++;
                $display("FAIL held_scan i=%0d rindex=%0d req=%b busy=%b",
                         i, bus.dirty_rindex, bus.wb_req, bus.flush_busy);
            end
            @(negedge clk);
        end
        man_ack = 1'b0;
        checks++;
        if (bus.flush_done !== 1'b1) begin
            errors++;
            $display("FAIL held_done got %b required 1", bus.flush_done);
        end
        @(negedge clk);
        checks++;
        if (bus.flush_busy !== 1'b0) begin
            errors++;
            $display("FAIL held_idle busy=%b required 0", bus.flush_busy);
        end
        @(negedge clk);
        checks++;
        if (bus.flush_busy !== 1'b1 || bus.dirty_rindex !== 3'd0) begin
            errors++;
            $display("FAIL held_restart busy=%b rindex=%0d required 1/0", bus.flush_busy, bus.dirty_rindex);
        end
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.flush_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL held_second_done timeout seen=0 required 1");
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_wb;
        bit seen;
        init_mem(8'h04);
        tag_mem[2] = 24'h000222;
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (bus.wb_req === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen || bus.wb_index !== 3'd2) begin
            errors++;
            $display("FAIL rstwb_reach seen=%b index=%0d required 1/2", seen, bus.wb_index);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.wb_req !== 1'b0 || bus.flush_busy !== 1'b0 || bus.dirty_load !== 1'b0 ||
            bus.wb_tag !== 24'd0) begin
            errors++;
            $display("FAIL rstwb_async req=%b busy=%b load=%b tag=%h required 0/0/0/0",
                     bus.wb_req, bus.flush_busy, bus.dirty_load, bus.wb_tag);
        end
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.flush_busy !== 1'b0 || bus.dirty_rindex !== 3'd0 || dirty_mem[2] !== 1'b1) begin
            errors++;
            $display("FAIL rstwb_after busy=%b rindex=%0d bit2=%b required 0/0/1",
                     bus.flush_busy, bus.dirty_rindex, dirty_mem[2]);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        man_ack  = 1'b0;
        auto_ack = 1'b0;
        init_mem(8'h00);
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b1;
        test_all_clean();
        test_single_dirty();
        test_last_dirty();
        test_all_dirty();
        test_start_held();
        test_reset_in_wb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cache_flush_walker

`default_nettype wire
